// File: rtl/div4_seq_ctrl_pkg.sv
// rtl/div4_seq_ctrl_pkg.sv - state encodings and iteration count for the 4-bit divider sequencer
package div4_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // One ITER cycle per quotient bit, counting 3 down to 0.
    localparam logic [1:0] DIV_CNT_INIT = 2'd3;

endpackage

// File: rtl/subr4.sv
// rtl/subr4.sv - 4-bit ripple-borrow subtractor, DIFF = A - B with DIFF[4] as the borrow out
module subr4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [4:0] DIFF
);

    logic [4:0] bw;

    assign bw[0] = 1'b0;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign DIFF[i]  = A[i] ^ B[i] ^ bw[i];
        assign bw[i+1]  = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & bw[i]);
    end

    assign DIFF[4] = bw[4];

endmodule

// File: rtl/div4_seq_ctrl.sv
// rtl/div4_seq_ctrl.sv - restoring 4-bit unsigned divider sequencer driving one subr4
// One quotient bit per ITER cycle; the result registers are only touched in FIN.
module div4_seq_ctrl
    import div4_seq_ctrl_pkg::*;
#(
    parameter int         WIDTH     = 4,
    parameter logic [3:0] DIV0_QUOT = 4'hF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [3:0] DIVIDEND,
    input  logic [3:0] DIVISOR,
    output logic       BUSY,
    output logic       DONE,
    output logic [3:0] QUOT,
    output logic [3:0] REM,
    output logic       DIV0
);

    if (WIDTH != 4) begin : g_width_err
        $error("div4_seq_ctrl: WIDTH must be 4");
    end

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] d_q, d_d;
    logic [3:0] q_q, q_d;
    logic [3:0] r_q, r_d;
    logic [3:0] n_q, n_d;
    logic       z_q, z_d;
    logic [3:0] quot_q, quot_d;
    logic [3:0] rem_q, rem_d;
    logic       div0_q, div0_d;

    logic [4:0] rs;
    logic [4:0] diff;
    logic       take;

    // R < D always holds after a step, so the stored remainder needs only 4 bits.
    assign rs = {r_q, q_q[3]};

    subr4 u_subr4 (
        .A    (rs[3:0]),
        .B    (d_q),
        .DIFF (diff)
    );

    assign take = rs[4] | ~diff[4];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        q_d     = q_q;
        r_d     = r_q;
        n_d     = n_q;
        z_d     = z_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        div0_d  = div0_q;
        BUSY    = 1'b0;
        DONE    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    d_d     = DIVISOR;
                    q_d     = DIVIDEND;
                    n_d     = DIVIDEND;
                    r_d     = 4'd0;
                    z_d     = (DIVISOR == 4'd0);
                    // Divide-by-zero spends a single ITER cycle so its DONE lands at T+2.
                    cnt_d   = (DIVISOR == 4'd0) ? 2'd0 : DIV_CNT_INIT;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                BUSY  = 1'b1;
                r_d   = take ? diff[3:0] : rs[3:0];
                q_d   = {q_q[2:0], take};
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd0) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                BUSY    = 1'b1;
                DONE    = 1'b1;
                state_d = S_IDLE;
                if (z_q) begin
                    quot_d = DIV0_QUOT;
                    rem_d  = n_q;
                    div0_d = 1'b1;
                end else begin
                    quot_d = q_q;
                    rem_d  = r_q;
                    div0_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            d_q     <= 4'd0;
            q_q     <= 4'd0;
            r_q     <= 4'd0;
            n_q     <= 4'd0;
            z_q     <= 1'b0;
            quot_q  <= 4'd0;
            rem_q   <= 4'd0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            q_q     <= q_d;
            r_q     <= r_d;
            n_q     <= n_d;
            z_q     <= z_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            div0_q  <= div0_d;
        end
    end

    assign QUOT = quot_q;
    assign REM  = rem_q;
    assign DIV0 = div0_q;

endmodule

// File: tb/tb_div4_seq_ctrl.sv
// tb/tb_div4_seq_ctrl.sv - directed, table-driven and exhaustive checks for div4_seq_ctrl
module tb_div4_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quot;
    logic [3:0] rem;
    logic       div0;

    int n_total;
    int n_pass;

    div4_seq_ctrl #(.WIDTH(4), .DIV0_QUOT(4'hF)) dut (
        .CLK      (clk),
        .RST      (rst),
        .START    (start),
        .DIVIDEND (dividend),
        .DIVISOR  (divisor),
        .BUSY     (busy),
        .DONE     (done),
        .QUOT     (quot),
        .REM      (rem),
        .DIV0     (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] n;
        logic [3:0] d;
        logic [3:0] q;
        logic [3:0] r;
        logic       z;
        int         lat;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Issues one request; lat is the cycle index of the DONE pulse (T+k), 100 if it pulsed twice.
    task automatic run_op(input logic [3:0] n, input logic [3:0] d, input bit noisy,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        dividend = n;
        divisor  = d;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        lat      = -1;
        busy_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) lat = (lat < 0) ? k : 100;
            if (noisy && k <= 5) begin
                start    = 1'($urandom_range(0, 1));
                dividend = 4'($urandom_range(0, 15));
                divisor  = 4'($urandom_range(0, 15));
            end else begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        int lat;
        int bc;
        int first_done;
        int last_done;
        int n_done;
        int gap_bad;
        int exp_q;
        int exp_r;

        n_total  = 0;
        n_pass   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;

        vt[0] = '{n: 4'd13, d: 4'd3,  q: 4'd4,  r: 4'd1,  z: 1'b0, lat: 5};
        vt[1] = '{n: 4'd15, d: 4'd1,  q: 4'd15, r: 4'd0,  z: 1'b0, lat: 5};
        vt[2] = '{n: 4'd7,  d: 4'd9,  q: 4'd0,  r: 4'd7,  z: 1'b0, lat: 5};
        vt[3] = '{n: 4'd15, d: 4'd15, q: 4'd1,  r: 4'd0,  z: 1'b0, lat: 5};
        vt[4] = '{n: 4'd0,  d: 4'd5,  q: 4'd0,  r: 4'd0,  z: 1'b0, lat: 5};
        vt[5] = '{n: 4'd14, d: 4'd0,  q: 4'hF,  r: 4'hE,  z: 1'b1, lat: 2};
        vt[6] = '{n: 4'd6,  d: 4'd4,  q: 4'd1,  r: 4'd2,  z: 1'b0, lat: 5};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_quot", int'(quot), 0);
        chk("reset_rem",  int'(rem),  0);
        chk("reset_div0", int'(div0), 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_op(vt[i].n, vt[i].d, 1'b0, lat, bc);
            chk($sformatf("vec%0d_done_cycle", i), lat, vt[i].lat);
            chk($sformatf("vec%0d_busy_cycles", i), bc, vt[i].lat);
            chk($sformatf("vec%0d_quot", i), int'(quot), int'(vt[i].q));
            chk($sformatf("vec%0d_rem", i),  int'(rem),  int'(vt[i].r));
            chk($sformatf("vec%0d_div0", i), int'(div0), int'(vt[i].z));
        end

        // START pulses and operand churn while busy must not disturb 13/3.
        run_op(4'd13, 4'd3, 1'b1, lat, bc);
        chk("noisy_done_cycle", lat, 5);
        chk("noisy_quot", int'(quot), 4);
        chk("noisy_rem",  int'(rem),  1);
        chk("noisy_div0", int'(div0), 0);

        // START held high: a DONE every 6 cycles, first at T+5.
        @(negedge clk);
        dividend   = 4'd9;
        divisor    = 4'd2;
        start      = 1'b1;
        first_done = -1;
        last_done  = -1;
        n_done     = 0;
        gap_bad    = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = k;
                if (last_done >= 0 && (k - last_done) != 6) gap_bad++;
                last_done = k;
            end
        end
        start = 1'b0;
        chk("b2b_first_done", first_done, 5);
        chk("b2b_done_count", n_done, 5);
        chk("b2b_gap_errors", gap_bad, 0);
        chk("b2b_quot", int'(quot), 4);
        chk("b2b_rem",  int'(rem),  1);
        repeat (6) @(negedge clk);

        // Reset in the middle of a division discards it.
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_quot", int'(quot), 0);
        chk("midrst_rem",  int'(rem),  0);
        rst    = 1'b0;
        n_done = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        chk("midrst_no_activity", n_done, 0);
        run_op(4'd13, 4'd3, 1'b0, lat, bc);
        chk("postrst_done_cycle", lat, 5);
        chk("postrst_quot", int'(quot), 4);
        chk("postrst_rem",  int'(rem),  1);

        // Every operand pair against integer division.
        for (int n = 0; n < 16; n++) begin
            for (int d = 0; d < 16; d++) begin
                run_op(4'(n), 4'(d), 1'b0, lat, bc);
                exp_q = (d == 0) ? 15 : n / d;
                exp_r = (d == 0) ? n  : n % d;
                chk($sformatf("ex_%0d_%0d_lat", n, d), lat, (d == 0) ? 2 : 5);
                chk($sformatf("ex_%0d_%0d_quot", n, d), int'(quot), exp_q);
                chk($sformatf("ex_%0d_%0d_rem", n, d),  int'(rem),  exp_r);
                chk($sformatf("ex_%0d_%0d_div0", n, d), int'(div0), (d == 0) ? 1 : 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
